// File: rtl/point_cal_pkg.sv
// Shared types and constants for the point calculator.
package point_cal_pkg;
   localparam int FRAC_BITS = 4;
   localparam int DEF_WIDTH = 14;
   localparam int DEF_X_MAX = 5119;
   localparam int DEF_Y_MAX = 3839;

   typedef enum logic [1:0] {IDLE, DIV, GEN, DONE} state_t;
endpackage

// File: rtl/point_cal_div.sv
// Iterative restoring divider: o_quot = floor((i_num << SLOPE_BITS) / i_den), with i_num <= i_den.
// One quotient bit per cycle. o_done rises SLOPE_BITS+1 edges after i_start.
module point_cal_div
   import point_cal_pkg::*;
#(
   parameter int DW         = DEF_WIDTH,
   parameter int SLOPE_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_start,
   input  logic [DW-1:0]         i_num,
   input  logic [DW-1:0]         i_den,
   output logic [SLOPE_BITS:0]   o_quot,
   output logic                  o_done
);
   localparam int CW = (SLOPE_BITS > 0) ? $clog2(SLOPE_BITS + 1) : 1;

   logic [DW:0]         r_rem;
   logic [DW-1:0]       r_den;
   logic [SLOPE_BITS:0] r_quot;
   logic [CW-1:0]       r_cnt;
   logic                r_busy;
   logic                r_done;

   logic                w_ge;
   logic [DW:0]         w_sub;

   // The numerator never exceeds the divisor, so the remainder starts as the
   // numerator itself and only the SLOPE_BITS+1 low quotient bits are needed.
   assign w_ge  = (r_rem >= {1'b0, r_den});
   assign w_sub = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_den  <= '0;
         r_quot <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else if (i_start) begin
         r_rem  <= {1'b0, i_num};
         r_den  <= i_den;
         r_quot <= '0;
         r_cnt  <= CW'(SLOPE_BITS);
         r_busy <= 1'b1;
         r_done <= 1'b0;
      end else if (r_busy) begin
         r_rem  <= {w_sub[DW-1:0], 1'b0};
         r_quot <= {r_quot[SLOPE_BITS-1:0], w_ge};
         r_cnt  <= r_cnt - 1'b1;
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
      end
   end

   assign o_quot = r_quot;
   assign o_done = r_done;
endmodule

// File: rtl/point_cal_seq.sv
// Handshaked inner/outer sample point generator along the centre->boundary ray.
// Build option: define POINT_CAL_CLAMP_EN to saturate outputs to [0, X_MAX]/[0, Y_MAX] instead of wrapping.
module point_cal_seq
   import point_cal_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int N_PTS      = 4,
   parameter int STEP_Q     = 48,
   parameter int SLOPE_BITS = 8,
   parameter int X_MAX      = DEF_X_MAX,
   parameter int Y_MAX      = DEF_Y_MAX
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         xc,
   input  logic [WIDTH-1:0]         yc,
   input  logic [WIDTH-1:0]         xb,
   input  logic [WIDTH-1:0]         yb,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_PTS*WIDTH-1:0]   new_xi,
   output logic [N_PTS*WIDTH-1:0]   new_yi,
   output logic [N_PTS*WIDTH-1:0]   new_xo,
   output logic [N_PTS*WIDTH-1:0]   new_yo,
   output logic [WIDTH-1:0]         xb_o,
   output logic [WIDTH-1:0]         yb_o
);
   localparam int AW = WIDTH + 2;
   localparam int CW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
   localparam int PW = SLOPE_BITS + 1 + $clog2(STEP_Q + 1);
   localparam logic signed [AW-1:0] STEP_MAJ = AW'(STEP_Q);
`ifdef POINT_CAL_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] f_reduce(input logic signed [AW-1:0] v, input int maxv);
      if (CLAMP_EN && (v < 0))
         return '0;
      else if (CLAMP_EN && (v > maxv))
         return WIDTH'(maxv);
      else
         return v[WIDTH-1:0];
   endfunction

   state_t                  r_state;
   logic                    r_degen, r_x_major, r_neg_x, r_neg_y, r_out_valid;
   logic [WIDTH-1:0]        r_xb, r_yb;
   logic signed [AW-1:0]    r_step_x, r_step_y;
   logic signed [AW-1:0]    r_acc_xo, r_acc_yo, r_acc_xi, r_acc_yi;
   logic [CW-1:0]           r_cnt;
   logic [WIDTH-1:0]        r_xo [N_PTS];
   logic [WIDTH-1:0]        r_yo [N_PTS];
   logic [WIDTH-1:0]        r_xi [N_PTS];
   logic [WIDTH-1:0]        r_yi [N_PTS];

   logic signed [WIDTH:0]   w_dx, w_dy, w_adx_s, w_ady_s;
   logic [WIDTH-1:0]        w_adx, w_ady, w_num, w_den;
   logic                    w_x_major, w_degen, w_accept, w_div_start, w_div_done;
   logic [SLOPE_BITS:0]     w_quot;
   logic [PW-1:0]           w_prod;
   logic signed [AW-1:0]    w_minor, w_mag_x, w_mag_y, w_step_x, w_step_y, w_bx, w_by;

   assign w_dx      = $signed({1'b0, xb}) - $signed({1'b0, xc});
   assign w_dy      = $signed({1'b0, yb}) - $signed({1'b0, yc});
   assign w_adx_s   = w_dx[WIDTH] ? -w_dx : w_dx;
   assign w_ady_s   = w_dy[WIDTH] ? -w_dy : w_dy;
   assign w_adx     = w_adx_s[WIDTH-1:0];
   assign w_ady     = w_ady_s[WIDTH-1:0];
   assign w_x_major = (w_adx >= w_ady);
   assign w_num     = w_x_major ? w_ady : w_adx;
   assign w_den     = w_x_major ? w_adx : w_ady;
   assign w_degen   = (w_dx == '0) && (w_dy == '0);
   assign w_accept  = (r_state == IDLE) && in_valid;
   assign w_div_start = w_accept && !w_degen;

   point_cal_div #(
      .DW         (WIDTH),
      .SLOPE_BITS (SLOPE_BITS)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_div_start),
      .i_num   (w_num),
      .i_den   (w_den),
      .o_quot  (w_quot),
      .o_done  (w_div_done)
   );

   // Minor step magnitude is truncated before the sign is applied.
   assign w_prod   = PW'(w_quot) * PW'(STEP_Q);
   assign w_minor  = AW'(w_prod >> SLOPE_BITS);
   assign w_mag_x  = r_degen ? '0 : (r_x_major ? STEP_MAJ : w_minor);
   assign w_mag_y  = r_degen ? '0 : (r_x_major ? w_minor : STEP_MAJ);
   assign w_step_x = r_neg_x ? -w_mag_x : w_mag_x;
   assign w_step_y = r_neg_y ? -w_mag_y : w_mag_y;
   assign w_bx     = {2'b00, r_xb};
   assign w_by     = {2'b00, r_yb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_degen     <= 1'b0;
         r_x_major   <= 1'b0;
         r_neg_x     <= 1'b0;
         r_neg_y     <= 1'b0;
         r_out_valid <= 1'b0;
         r_xb        <= '0;
         r_yb        <= '0;
         r_step_x    <= '0;
         r_step_y    <= '0;
         r_acc_xo    <= '0;
         r_acc_yo    <= '0;
         r_acc_xi    <= '0;
         r_acc_yi    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_xb      <= xb;
                  r_yb      <= yb;
                  r_degen   <= w_degen;
                  r_x_major <= w_x_major;
                  r_neg_x   <= w_dx[WIDTH];
                  r_neg_y   <= w_dy[WIDTH];
                  r_state   <= DIV;
               end
            end
            DIV: begin
               // A degenerate ray skips the divider but still spends one cycle here.
               if (r_degen || w_div_done) begin
                  r_step_x <= w_step_x;
                  r_step_y <= w_step_y;
                  r_acc_xo <= w_bx + w_step_x;
                  r_acc_yo <= w_by + w_step_y;
                  r_acc_xi <= w_bx - w_step_x;
                  r_acc_yi <= w_by - w_step_y;
                  r_cnt    <= '0;
                  r_state  <= GEN;
               end
            end
            GEN: begin
               r_acc_xo <= r_acc_xo + r_step_x;
               r_acc_yo <= r_acc_yo + r_step_y;
               r_acc_xi <= r_acc_xi - r_step_x;
               r_acc_yi <= r_acc_yi - r_step_y;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CW'(N_PTS - 1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < N_PTS; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_xo[gi] <= '0;
            r_yo[gi] <= '0;
            r_xi[gi] <= '0;
            r_yi[gi] <= '0;
         end else if ((r_state == GEN) && (r_cnt == CW'(gi))) begin
            r_xo[gi] <= f_reduce(r_acc_xo, X_MAX);
            r_yo[gi] <= f_reduce(r_acc_yo, Y_MAX);
            r_xi[gi] <= f_reduce(r_acc_xi, X_MAX);
            r_yi[gi] <= f_reduce(r_acc_yi, Y_MAX);
         end
      end
      assign new_xo[gi*WIDTH +: WIDTH] = r_xo[gi];
      assign new_yo[gi*WIDTH +: WIDTH] = r_yo[gi];
      assign new_xi[gi*WIDTH +: WIDTH] = r_xi[gi];
      assign new_yi[gi*WIDTH +: WIDTH] = r_yi[gi];
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign xb_o      = r_xb;
   assign yb_o      = r_yb;
endmodule

// File: tb/tb_point_cal_seq.sv
// Directed bench for point_cal_seq; expectations follow POINT_CAL_CLAMP_EN when defined.
module tb_point_cal_seq;
   localparam int W = 14;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [W-1:0]   xc = '0, yc = '0, xb = '0, yb = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [N*W-1:0] new_xi, new_yi, new_xo, new_yo;
   logic [W-1:0]   xb_o, yb_o;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   point_cal_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .xc        (xc),
      .yc        (yc),
      .xb        (xb),
      .yb        (yb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .new_xi    (new_xi),
      .new_yi    (new_yi),
      .new_xo    (new_xo),
      .new_yo    (new_yo),
      .xb_o      (xb_o),
      .yb_o      (yb_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_lanes(input string tag, input logic [N*W-1:0] bus,
                            input int e0, input int e1, input int e2, input int e3);
      int e [N];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int k = 0; k < N; k++)
         chk($sformatf("%s[%0d]", tag, k), bus[k*W +: W], e[k]);
      $display("check %s lanes: %0d %0d %0d %0d", tag,
               bus[0 +: W], bus[W +: W], bus[2*W +: W], bus[3*W +: W]);
   endtask

   // Drives one request, waits for out_valid and checks the latency.
   task automatic send(input string tag, input int a, input int b, input int c, input int d,
                       input int lat);
      int n;
      @(negedge clk);
      xc = W'(a); yc = W'(b); xb = W'(c); yb = W'(d);
      in_valid = 1'b1;
      chk({tag, "_in_ready_pre"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_latency"}, n, lat);
      $display("request %s xc=%0d yc=%0d xb=%0d yb=%0d latency=%0d", tag, a, b, c, d, n);
   endtask

   task automatic release_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_in_ready_back"}, in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1 chk("rst_out_valid", out_valid, 0);
      chk("rst_xo", new_xo, 0);
      chk("rst_xb_o", xb_o, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("rst_in_ready", in_ready, 1);

      // 1. Nominal ray
      send("nominal", 1798, 1179, 3968, 1328, 14);
      chk_lanes("nom_xo", new_xo, 4016, 4064, 4112, 4160);
      chk_lanes("nom_yo", new_yo, 1331, 1334, 1337, 1340);
      chk_lanes("nom_xi", new_xi, 3920, 3872, 3824, 3776);
      chk_lanes("nom_yi", new_yi, 1325, 1322, 1319, 1316);
      chk("nom_xb_o", xb_o, 3968);
      chk("nom_yb_o", yb_o, 1328);
      release_result("nom");
      chk_lanes("nom_hold_xo", new_xo, 4016, 4064, 4112, 4160);

      // 2. Degenerate
      send("degen", 1000, 500, 1000, 500, 5);
      chk_lanes("deg_xo", new_xo, 1000, 1000, 1000, 1000);
      chk_lanes("deg_yo", new_yo, 500, 500, 500, 500);
      chk_lanes("deg_xi", new_xi, 1000, 1000, 1000, 1000);
      chk_lanes("deg_yi", new_yi, 500, 500, 500, 500);
      release_result("deg");

      // 3. Clamp / wrap at the right edge
      send("clamp", 4800, 1600, 5100, 1600, 14);
`ifdef POINT_CAL_CLAMP_EN
      chk_lanes("clp_xo", new_xo, 5119, 5119, 5119, 5119);
`else
      chk_lanes("clp_xo", new_xo, 5148, 5196, 5244, 5292);
`endif
      chk_lanes("clp_xi", new_xi, 5052, 5004, 4956, 4908);
      chk_lanes("clp_yo", new_yo, 1600, 1600, 1600, 1600);
      chk_lanes("clp_yi", new_yi, 1600, 1600, 1600, 1600);
      release_result("clp");

      // 4. Negative direction
      send("neg", 100, 800, 40, 800, 14);
`ifdef POINT_CAL_CLAMP_EN
      chk_lanes("neg_xo", new_xo, 0, 0, 0, 0);
`else
      chk_lanes("neg_xo", new_xo, 16376, 16328, 16280, 16232);
`endif
      chk_lanes("neg_xi", new_xi, 88, 136, 184, 232);
      chk_lanes("neg_yo", new_yo, 800, 800, 800, 800);
      release_result("neg");

      // 5. Backpressure with a competing request held high
      send("bp", 1798, 1179, 3968, 1328, 14);
      @(negedge clk);
      xc = 14'd10; yc = 14'd10; xb = 14'd900; yb = 14'd20;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_xo0", new_xo[0 +: W], 4016);
         chk("bp_yi3", new_yi[3*W +: W], 1316);
         chk("bp_xb_o", xb_o, 3968);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_in_ready_after", in_ready, 1);
      chk("bp_valid_after", out_valid, 0);
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("bp_ignored_valid", out_valid, 0);
      chk("bp_ignored_xb", xb_o, 3968);
      chk("bp_idle", in_ready, 1);

      // 6. Reset mid-DIV
      @(negedge clk);
      xc = 14'd4800; yc = 14'd1600; xb = 14'd5100; yb = 14'd1600;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_xo", new_xo, 0);
      chk("mid_rst_yi", new_yi, 0);
      chk("mid_rst_xb_o", xb_o, 0);
      @(negedge clk) rst_n = 1'b1;
      send("after_rst", 1798, 1179, 3968, 1328, 14);
      chk_lanes("ar_xo", new_xo, 4016, 4064, 4112, 4160);
      chk_lanes("ar_yi", new_yi, 1325, 1322, 1319, 1316);
      release_result("ar");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
